// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Covers opcodes, ALU codes, the T-state encoding and the packed control vector.
package cpu_pkg;

    localparam int OPW  = 5;
    localparam int ALUW = 5;

    localparam logic [OPW-1:0] OP_LD         = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI        = 5'b00001;
    localparam logic [OPW-1:0] OP_ST         = 5'b00010;
    localparam logic [OPW-1:0] OP_RTYPE_LO   = 5'b00011;
    localparam logic [OPW-1:0] OP_RTYPE_HI   = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI       = 5'b01100;
    localparam logic [OPW-1:0] OP_BR         = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP        = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT       = 5'b11011;

    localparam logic [ALUW-1:0] ALU_ADD   = 5'b00011;
    localparam logic [ALUW-1:0] ALU_INCPC = 5'b11111;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef struct packed {
        logic            run;
        logic            hi_in;
        logic            lo_in;
        logic            z_in;
        logic            pc_in;
        logic            mdr_in;
        logic            mar_in;
        logic            y_in;
        logic            oport_in;
        logic            ir_in;
        logic            hi_out;
        logic            lo_out;
        logic            z_hi_out;
        logic            z_lo_out;
        logic            pc_out;
        logic            mdr_out;
        logic            iport_out;
        logic            c_out;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            r_in;
        logic            r_out;
        logic            ba_out;
        logic            con_in;
        logic            mem_read;
        logic            mem_write;
        logic [ALUW-1:0] alu_code;
    } ctrl_t;

    function automatic logic is_rtype(input logic [OPW-1:0] op);
        return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decoder for the sequencer.
// Maps (T-state, opcode, branch condition) to the full DataPath control vector.
module cu_decode
    import cpu_pkg::*;
(
    input  state_t          state,
    input  logic [OPW-1:0]  opcode,
    input  logic            con_out,
    output ctrl_t           ctrl
);

    logic is_ld;
    logic is_ldi;
    logic is_st;
    logic is_rt;
    logic is_addi;
    logic is_br;

    assign is_ld   = (opcode == OP_LD);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_st   = (opcode == OP_ST);
    assign is_rt   = is_rtype(opcode);
    assign is_addi = (opcode == OP_ADDI);
    assign is_br   = (opcode == OP_BR);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_T0: begin
                ctrl.run      = 1'b1;
                ctrl.pc_out   = 1'b1;
                ctrl.mar_in   = 1'b1;
                ctrl.z_in     = 1'b1;
                ctrl.alu_code = ALU_INCPC;
            end
            S_T1: begin
                ctrl.run      = 1'b1;
                ctrl.z_lo_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl.run     = 1'b1;
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                ctrl.run = 1'b1;
                if (is_ld || is_ldi || is_st) begin
                    ctrl.grb    = 1'b1;
                    ctrl.ba_out = 1'b1;
                    ctrl.y_in   = 1'b1;
                end else if (is_rt || is_addi) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                end else if (is_br) begin
                    ctrl.gra    = 1'b1;
                    ctrl.r_out  = 1'b1;
                    ctrl.con_in = 1'b1;
                end
            end
            S_T4: begin
                ctrl.run = 1'b1;
                if (is_ld || is_ldi || is_st || is_addi) begin
                    ctrl.c_out    = 1'b1;
                    ctrl.z_in     = 1'b1;
                    ctrl.alu_code = ALU_ADD;
                end else if (is_rt) begin
                    ctrl.grc      = 1'b1;
                    ctrl.r_out    = 1'b1;
                    ctrl.z_in     = 1'b1;
                    ctrl.alu_code = opcode;
                end else if (is_br) begin
                    ctrl.pc_out = 1'b1;
                    ctrl.y_in   = 1'b1;
                end
            end
            S_T5: begin
                ctrl.run = 1'b1;
                if (is_ld || is_st) begin
                    ctrl.z_lo_out = 1'b1;
                    ctrl.mar_in   = 1'b1;
                end else if (is_ldi || is_rt || is_addi) begin
                    ctrl.z_lo_out = 1'b1;
                    ctrl.gra      = 1'b1;
                    ctrl.r_in     = 1'b1;
                end else if (is_br) begin
                    ctrl.c_out    = 1'b1;
                    ctrl.z_in     = 1'b1;
                    ctrl.alu_code = ALU_ADD;
                end
            end
            S_T6: begin
                ctrl.run = 1'b1;
                if (is_ld) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.mdr_in   = 1'b1;
                end else if (is_st) begin
                    // mem_read stays low so the MDR input mux takes the bus
                    ctrl.gra    = 1'b1;
                    ctrl.r_out  = 1'b1;
                    ctrl.mdr_in = 1'b1;
                end else if (is_br && con_out) begin
                    ctrl.pc_in    = 1'b1;
                    ctrl.z_lo_out = 1'b1;
                end
            end
            S_T7: begin
                ctrl.run = 1'b1;
                if (is_ld) begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end else if (is_st) begin
                    ctrl.mem_write = 1'b1;
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer driving every DataPath control input.
// Holds the T-state register and next-state logic; control words come from cu_decode.
module control_unit
    import cpu_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             ConOut,
    input  logic             stop,
    output logic             run,
    output logic             HiIn,
    output logic             LoIn,
    output logic             ZIn,
    output logic             PCIn,
    output logic             MDRIn,
    output logic             MARIn,
    output logic             YIn,
    output logic             OPortIn,
    output logic             IRIn,
    output logic             HiOut,
    output logic             LoOut,
    output logic             ZHiOut,
    output logic             ZLoOut,
    output logic             PCOut,
    output logic             MDROut,
    output logic             IPortOut,
    output logic             COut,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             RIn,
    output logic             ROut,
    output logic             BAOut,
    output logic             Conin,
    output logic             memread,
    output logic             memwrite,
    output logic [ALUW-1:0]  ALUCode,
    output logic             initMem
);

    state_t         state;
    state_t         next_state;
    state_t         boundary;
    logic [OPW-1:0] opcode;
    ctrl_t          ctrl;
    logic           ir_unused;

    assign opcode    = IR[31:27];
    assign ir_unused = ^IR[26:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= S_RESET;
        else       state <= next_state;
    end

    // stop only takes effect on an edge that would otherwise start a new fetch
    assign boundary = stop ? S_HALT : S_T0;

    always_comb begin
        next_state = state;
        unique case (state)
            S_RESET: next_state = boundary;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                if (opcode == OP_HALT)
                    next_state = S_HALT;
                else if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST ||
                         is_rtype(opcode) || opcode == OP_ADDI || opcode == OP_BR)
                    next_state = S_T4;
                else
                    next_state = boundary;
            end
            S_T4:    next_state = S_T5;
            S_T5: begin
                if (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR)
                    next_state = S_T6;
                else
                    next_state = boundary;
            end
            S_T6: begin
                if (opcode == OP_LD || opcode == OP_ST)
                    next_state = S_T7;
                else
                    next_state = boundary;
            end
            S_T7:    next_state = boundary;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    cu_decode u_decode (
        .state   (state),
        .opcode  (opcode),
        .con_out (ConOut),
        .ctrl    (ctrl)
    );

    assign run      = ctrl.run;
    assign HiIn     = ctrl.hi_in;
    assign LoIn     = ctrl.lo_in;
    assign ZIn      = ctrl.z_in;
    assign PCIn     = ctrl.pc_in;
    assign MDRIn    = ctrl.mdr_in;
    assign MARIn    = ctrl.mar_in;
    assign YIn      = ctrl.y_in;
    assign OPortIn  = ctrl.oport_in;
    assign IRIn     = ctrl.ir_in;
    assign HiOut    = ctrl.hi_out;
    assign LoOut    = ctrl.lo_out;
    assign ZHiOut   = ctrl.z_hi_out;
    assign ZLoOut   = ctrl.z_lo_out;
    assign PCOut    = ctrl.pc_out;
    assign MDROut   = ctrl.mdr_out;
    assign IPortOut = ctrl.iport_out;
    assign COut     = ctrl.c_out;
    assign Gra      = ctrl.gra;
    assign Grb      = ctrl.grb;
    assign Grc      = ctrl.grc;
    assign RIn      = ctrl.r_in;
    assign ROut     = ctrl.r_out;
    assign BAOut    = ctrl.ba_out;
    assign Conin    = ctrl.con_in;
    assign memread  = ctrl.mem_read;
    assign memwrite = ctrl.mem_write;
    assign ALUCode  = ctrl.alu_code;
    assign initMem  = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class through its T-states.
// Expected control words are hand-built from per-signal bit masks.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        ConOut;
    logic        stop;
    logic run, HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, initMem;
    logic [4:0] ALUCode;

    int error_count = 0;
    int check_count = 0;

    always #5 clock = ~clock;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut), .stop(stop),
        .run(run), .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn),
        .MDRIn(MDRIn), .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
        .Conin(Conin), .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .initMem(initMem)
    );

    logic [27:0] obs;
    assign obs = {run, HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
                  Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, initMem};

    localparam logic [27:0] RUN      = 28'd1 << 27;
    localparam logic [27:0] ZIN      = 28'd1 << 24;
    localparam logic [27:0] PCIN     = 28'd1 << 23;
    localparam logic [27:0] MDRIN    = 28'd1 << 22;
    localparam logic [27:0] MARIN    = 28'd1 << 21;
    localparam logic [27:0] YIN      = 28'd1 << 20;
    localparam logic [27:0] IRIN     = 28'd1 << 18;
    localparam logic [27:0] ZLOOUT   = 28'd1 << 14;
    localparam logic [27:0] PCOUT    = 28'd1 << 13;
    localparam logic [27:0] MDROUT   = 28'd1 << 12;
    localparam logic [27:0] COUT     = 28'd1 << 10;
    localparam logic [27:0] GRA      = 28'd1 << 9;
    localparam logic [27:0] GRB      = 28'd1 << 8;
    localparam logic [27:0] GRC      = 28'd1 << 7;
    localparam logic [27:0] RIN      = 28'd1 << 6;
    localparam logic [27:0] ROUT     = 28'd1 << 5;
    localparam logic [27:0] BAOUT    = 28'd1 << 4;
    localparam logic [27:0] CONIN    = 28'd1 << 3;
    localparam logic [27:0] MEMREAD  = 28'd1 << 2;
    localparam logic [27:0] MEMWRITE = 28'd1 << 1;
    localparam logic [4:0]  ADD      = 5'b00011;
    localparam logic [4:0]  INCPC    = 5'b11111;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Checks the current cycle's control word, then moves to the next cycle.
    task automatic expectCycle(input string tag, input logic [27:0] ctrl,
                               input logic [4:0] alu);
        int drivers;
        drivers = int'(PCOut) + int'(MDROut) + int'(ZLoOut) + int'(ZHiOut) +
                  int'(HiOut) + int'(LoOut) + int'(IPortOut) + int'(COut) +
                  int'(ROut) + int'(BAOut);
        checkOutput({tag, "_ctrl"}, {4'd0, obs}, {4'd0, ctrl});
        checkOutput({tag, "_alu"}, {27'd0, ALUCode}, {27'd0, alu});
        checkOutput({tag, "_bus"}, {31'd0, (drivers <= 1) && !(memread && memwrite)}, 32'd1);
        @(negedge clock);
    endtask

    // Loads the instruction and walks the common fetch cycles.
    task automatic applyStimulus(input string tag, input logic [4:0] op, input logic con);
        IR     = {op, 4'd2, 4'd3, 19'h00abc};
        ConOut = con;
        expectCycle({tag, "_T0"}, RUN | PCOUT | MARIN | ZIN, INCPC);
        expectCycle({tag, "_T1"}, RUN | ZLOOUT | PCIN | MEMREAD | MDRIN, 5'd0);
        expectCycle({tag, "_T2"}, RUN | MDROUT | IRIN, 5'd0);
    endtask

    initial begin
        clear  = 1'b1;
        stop   = 1'b0;
        ConOut = 1'b0;
        IR     = 32'd0;
        @(negedge clock);
        checkOutput("reset_ctrl", {4'd0, obs}, 32'd0);
        checkOutput("reset_alu", {27'd0, ALUCode}, 32'd0);
        clear = 1'b0;
        @(negedge clock);

        applyStimulus("ldi", 5'b00001, 1'b0);
        expectCycle("ldi_T3", RUN | GRB | BAOUT | YIN, 5'd0);
        expectCycle("ldi_T4", RUN | COUT | ZIN, ADD);
        expectCycle("ldi_T5", RUN | ZLOOUT | GRA | RIN, 5'd0);

        applyStimulus("ld", 5'b00000, 1'b1);
        expectCycle("ld_T3", RUN | GRB | BAOUT | YIN, 5'd0);
        expectCycle("ld_T4", RUN | COUT | ZIN, ADD);
        expectCycle("ld_T5", RUN | ZLOOUT | MARIN, 5'd0);
        expectCycle("ld_T6", RUN | MEMREAD | MDRIN, 5'd0);
        expectCycle("ld_T7", RUN | MDROUT | GRA | RIN, 5'd0);

        applyStimulus("st", 5'b00010, 1'b0);
        expectCycle("st_T3", RUN | GRB | BAOUT | YIN, 5'd0);
        expectCycle("st_T4", RUN | COUT | ZIN, ADD);
        expectCycle("st_T5", RUN | ZLOOUT | MARIN, 5'd0);
        expectCycle("st_T6", RUN | GRA | ROUT | MDRIN, 5'd0);
        expectCycle("st_T7", RUN | MEMWRITE, 5'd0);

        applyStimulus("add", 5'b00011, 1'b0);
        expectCycle("add_T3", RUN | GRB | ROUT | YIN, 5'd0);
        expectCycle("add_T4", RUN | GRC | ROUT | ZIN, 5'b00011);
        expectCycle("add_T5", RUN | ZLOOUT | GRA | RIN, 5'd0);

        applyStimulus("rlast", 5'b01011, 1'b0);
        expectCycle("rlast_T3", RUN | GRB | ROUT | YIN, 5'd0);
        expectCycle("rlast_T4", RUN | GRC | ROUT | ZIN, 5'b01011);
        expectCycle("rlast_T5", RUN | ZLOOUT | GRA | RIN, 5'd0);

        applyStimulus("addi", 5'b01100, 1'b0);
        expectCycle("addi_T3", RUN | GRB | ROUT | YIN, 5'd0);
        expectCycle("addi_T4", RUN | COUT | ZIN, ADD);
        expectCycle("addi_T5", RUN | ZLOOUT | GRA | RIN, 5'd0);

        applyStimulus("brt", 5'b10010, 1'b1);
        expectCycle("brt_T3", RUN | GRA | ROUT | CONIN, 5'd0);
        expectCycle("brt_T4", RUN | PCOUT | YIN, 5'd0);
        expectCycle("brt_T5", RUN | COUT | ZIN, ADD);
        expectCycle("brt_T6", RUN | PCIN | ZLOOUT, 5'd0);

        applyStimulus("brn", 5'b10010, 1'b0);
        expectCycle("brn_T3", RUN | GRA | ROUT | CONIN, 5'd0);
        expectCycle("brn_T4", RUN | PCOUT | YIN, 5'd0);
        expectCycle("brn_T5", RUN | COUT | ZIN, ADD);
        expectCycle("brn_T6", RUN, 5'd0);

        applyStimulus("nop", 5'b11010, 1'b1);
        expectCycle("nop_T3", RUN, 5'd0);

        applyStimulus("undef", 5'b10000, 1'b0);
        expectCycle("undef_T3", RUN, 5'd0);

        applyStimulus("halt", 5'b11011, 1'b0);
        expectCycle("halt_T3", RUN, 5'd0);
        for (int i = 0; i < 20; i++) expectCycle("halt_hold", 28'd0, 5'd0);

        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        applyStimulus("stopadd", 5'b00011, 1'b0);
        expectCycle("stopadd_T3", RUN | GRB | ROUT | YIN, 5'd0);
        stop = 1'b1;
        expectCycle("stopadd_T4", RUN | GRC | ROUT | ZIN, 5'b00011);
        expectCycle("stopadd_T5", RUN | ZLOOUT | GRA | RIN, 5'd0);
        for (int i = 0; i < 3; i++) expectCycle("stop_halt", 28'd0, 5'd0);
        stop = 1'b0;
        expectCycle("stop_stays", 28'd0, 5'd0);

        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        applyStimulus("clrld", 5'b00000, 1'b0);
        expectCycle("clrld_T3", RUN | GRB | BAOUT | YIN, 5'd0);
        expectCycle("clrld_T4", RUN | COUT | ZIN, ADD);
        checkOutput("clrld_T5", {4'd0, obs}, {4'd0, RUN | ZLOOUT | MARIN});
        clear = 1'b1;
        #1;
        checkOutput("clrld_async_ctrl", {4'd0, obs}, 32'd0);
        checkOutput("clrld_async_alu", {27'd0, ALUCode}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        expectCycle("restart_T0", RUN | PCOUT | MARIN | ZIN, INCPC);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
